// File: rtl/mode_register_pkg.sv
// Shared encodings for the mode register: word-op and E-op codes produced by
// the priority decoder and consumed by the datapath (and control-unit checks).
package mode_register_pkg;

   // Word operation selected for this cycle; exactly one executes.
   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_CLR  = 3'd1,
      OP_LOAD = 3'd2,
      OP_INC  = 3'd3,
      OP_DEC  = 3'd4,
      OP_SHL  = 3'd5,
      OP_SHR  = 3'd6
   } op_e;

   // Explicit E operation; overrides any E effect of the word op.
   typedef enum logic [1:0] {
      E_HOLD = 2'd0,
      E_CLR  = 2'd1,
      E_CMP  = 2'd2
   } eop_e;

endpackage

// File: rtl/mode_register_decode.sv
// Combinational priority encoder: request lines -> one word op and one E op.
// Word priority clr > load > incr > decr > shl > shr; E priority e_clr > e_cmp.
module mode_register_decode
   import mode_register_pkg::*;
(
   input  logic clr_i,
   input  logic write_enable_i,
   input  logic incr_i,
   input  logic decr_i,
   input  logic shl_i,
   input  logic shr_i,
   input  logic e_clr_i,
   input  logic e_cmp_i,
   output op_e  op_o,
   output eop_e eop_o
);

   // Select the highest-priority word op; lower requests are dropped.
   always_comb begin
      op_o = OP_HOLD;
      if      (clr_i)          op_o = OP_CLR;
      else if (write_enable_i) op_o = OP_LOAD;
      else if (incr_i)         op_o = OP_INC;
      else if (decr_i)         op_o = OP_DEC;
      else if (shl_i)          op_o = OP_SHL;
      else if (shr_i)          op_o = OP_SHR;
   end

   // Select the explicit E op.
   always_comb begin
      eop_o = E_HOLD;
      if      (e_clr_i) eop_o = E_CLR;
      else if (e_cmp_i) eop_o = E_CMP;
   end

endmodule

// File: rtl/mode_register.sv
// Datapath word register with extend bit E, wrap/saturating inc/dec,
// shift/rotate through E, and registered zero/ones/wrapped status flags.
module mode_register
   import mode_register_pkg::*;
#(
   parameter int              WORD        = 16,
   parameter bit              SATURATE    = 1'b0,
   parameter logic [WORD-1:0] RESET_VALUE = '0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            clr,
   input  logic            write_enable,
   input  logic            incr,
   input  logic            decr,
   input  logic            shl,
   input  logic            shr,
   input  logic            rot,
   input  logic            ser_in,
   input  logic            e_clr,
   input  logic            e_cmp,
   input  logic [WORD-1:0] DATA,
   output logic [WORD-1:0] OUT,
   output logic            E,
   output logic            zero,
   output logic            ones
   ,
   output logic            wrapped
);

   localparam logic [WORD-1:0] ONE = {{(WORD-1){1'b0}}, 1'b1};

   op_e             op;
   eop_e            eop;
   logic [WORD-1:0] out_q, out_d;
   logic            e_q, e_d;
   logic            zero_q, zero_d;
   logic            ones_q, ones_d;
   logic            wrapped_q, wrapped_d;
   logic            fill;

   mode_register_decode u_decode (
      .clr_i          (clr),
      .write_enable_i (write_enable),
      .incr_i         (incr),
      .decr_i         (decr),
      .shl_i          (shl),
      .shr_i          (shr),
      .e_clr_i        (e_clr),
      .e_cmp_i        (e_cmp),
      .op_o           (op),
      .eop_o          (eop)
   );

   // Bit shifted in: E when rotating, the serial input otherwise.
   assign fill = rot ? e_q : ser_in;

   // Next-state word, E and flags; flags follow the next word so they are
   // always coherent with OUT in the cycle they are visible.
   always_comb begin
      out_d     = out_q;
      e_d       = e_q;
      wrapped_d = 1'b0;
      case (op)
         OP_CLR:  out_d = '0;
         OP_LOAD: out_d = DATA;
         OP_INC: begin
            if (&out_q) begin
               wrapped_d = 1'b1;
               if (!SATURATE) begin
                  out_d = '0;
                  e_d   = 1'b1;
               end
            end else begin
               out_d = out_q + ONE;
            end
         end
         OP_DEC: begin
            if (out_q == '0) begin
               wrapped_d = 1'b1;
               if (!SATURATE) begin
                  out_d = '1;
                  e_d   = 1'b0;
               end
            end else begin
               out_d = out_q - ONE;
            end
         end
         OP_SHL: begin
            out_d = {out_q[WORD-2:0], fill};
            e_d   = out_q[WORD-1];
         end
         OP_SHR: begin
            out_d = {fill, out_q[WORD-1:1]};
            e_d   = out_q[0];
         end
         default: ;
      endcase
      // Explicit E ops win over whatever the word op did to E.
      case (eop)
         E_CLR:   e_d = 1'b0;
         E_CMP:   e_d = ~e_q;
         default: ;
      endcase
      zero_d = (out_d == '0);
      ones_d = &out_d;
   end

   // State and flag registers; reset also kills any pending wrap pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_q     <= RESET_VALUE;
         e_q       <= 1'b0;
         zero_q    <= (RESET_VALUE == '0);
         ones_q    <= &RESET_VALUE;
         wrapped_q <= 1'b0;
      end else begin
         out_q     <= out_d;
         e_q       <= e_d;
         zero_q    <= zero_d;
         ones_q    <= ones_d;
         wrapped_q <= wrapped_d;
      end
   end

   assign OUT     = out_q;
   assign E       = e_q;
   assign zero    = zero_q;
   assign ones    = ones_q;
   assign wrapped = wrapped_q;

endmodule

// File: tb/tb_mode_register.sv
// Bench for mode_register: one wrapping instance and one saturating instance
// share a command bus; an arithmetic reference model tracks both.
module tb_mode_register;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clr, we, inc, dec, shl, shr, rot, ser, eclr, ecmp;
   logic [15:0] data;
   logic [15:0] out0, out1;
   logic        e0, z0, o0, w0, e1, z1, o1, w1;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state per instance (0 = wrap, 1 = saturate).
   int mo[2];
   bit me[2];
   bit mw[2];
   int rv[2] = '{32'h0100, 32'hFFF0};

   always #5 clk = ~clk;

   mode_register #(.WORD(16), .SATURATE(1'b0), .RESET_VALUE(16'h0100)) dut0 (
      .clk(clk), .reset_n(rst_n), .clr(clr), .write_enable(we), .incr(inc),
      .decr(dec), .shl(shl), .shr(shr), .rot(rot), .ser_in(ser),
      .e_clr(eclr), .e_cmp(ecmp), .DATA(data), .OUT(out0), .E(e0),
      .zero(z0), .ones(o0), .wrapped(w0));

   mode_register #(.WORD(16), .SATURATE(1'b1), .RESET_VALUE(16'hFFF0)) dut1 (
      .clk(clk), .reset_n(rst_n), .clr(clr), .write_enable(we), .incr(inc),
      .decr(dec), .shl(shl), .shr(shr), .rot(rot), .ser_in(ser),
      .e_clr(eclr), .e_cmp(ecmp), .DATA(data), .OUT(out1), .E(e1),
      .zero(z1), .ones(o1), .wrapped(w1));

   // Command bit positions: {clr,we,inc,dec,shl,shr,rot,ser,eclr,ecmp}
   localparam logic [9:0] C_CLR = 10'b1000000000, C_WE  = 10'b0100000000,
                          C_INC = 10'b0010000000, C_DEC = 10'b0001000000,
                          C_SHL = 10'b0000100000, C_SHR = 10'b0000010000,
                          C_ROT = 10'b0000001000, C_SER = 10'b0000000100,
                          C_ECL = 10'b0000000010, C_ECM = 10'b0000000001;

   typedef struct {
      logic [9:0]  cmd;
      logic [15:0] data;
      logic [15:0] out;
      logic        e, z, o, w;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
      n_cmp++;
      if (act !== ex) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, ex);
      end
   endtask

   task automatic drive(input logic [9:0] c, input logic [15:0] d);
      {clr, we, inc, dec, shl, shr, rot, ser, eclr, ecmp} = c;
      data = d;
   endtask

   task automatic model_reset();
      for (int s = 0; s < 2; s++) begin
         mo[s] = rv[s]; me[s] = 1'b0; mw[s] = 1'b0;
      end
   endtask

   // Next state from the operation rules, using plain integer arithmetic.
   task automatic model_step();
      for (int s = 0; s < 2; s++) begin
         int v, nv, f;
         bit ne, nw;
         v = mo[s]; nv = v; ne = me[s]; nw = 1'b0;
         f = rot ? int'(me[s]) : int'(ser);
         if (clr) nv = 0;
         else if (we) nv = int'(data);
         else if (inc) begin
            if (v == 65535) begin
               nw = 1'b1;
               if (s == 0) begin nv = 0; ne = 1'b1; end
            end else nv = v + 1;
         end else if (dec) begin
            if (v == 0) begin
               nw = 1'b1;
               if (s == 0) begin nv = 65535; ne = 1'b0; end
            end else nv = v - 1;
         end else if (shl) begin
            nv = (v * 2) % 65536 + f;
            ne = (v / 32768) != 0;
         end else if (shr) begin
            nv = v / 2 + f * 32768;
            ne = (v % 2) != 0;
         end
         if (eclr) ne = 1'b0;
         else if (ecmp) ne = ~me[s];
         mo[s] = nv; me[s] = ne; mw[s] = nw;
      end
   endtask

   task automatic cmp_all(input string tag);
      chk({tag, " out0"}, 32'(out0), 32'(mo[0]));
      chk({tag, " e0"},   32'(e0),   32'(me[0]));
      chk({tag, " z0"},   32'(z0),   32'(mo[0] == 0));
      chk({tag, " o0"},   32'(o0),   32'(mo[0] == 65535));
      chk({tag, " w0"},   32'(w0),   32'(mw[0]));
      chk({tag, " out1"}, 32'(out1), 32'(mo[1]));
      chk({tag, " e1"},   32'(e1),   32'(me[1]));
      chk({tag, " z1"},   32'(z1),   32'(mo[1] == 0));
      chk({tag, " o1"},   32'(o1),   32'(mo[1] == 65535));
      chk({tag, " w1"},   32'(w1),   32'(mw[1]));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_step();
      #1;
      cmp_all(tag);
   endtask

   initial begin
      // Hand-computed sequence for the wrapping instance, starting at 0100/E=0.
      tbl[0]  = '{C_WE, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1]  = '{C_INC, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
      tbl[2]  = '{10'd0, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{C_DEC, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[4]  = '{C_WE, 16'h8001, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{C_SHL | C_ROT, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{C_SHR | C_ROT, 16'h0000, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{C_WE, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{C_SHR | C_SER, 16'h0000, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{C_WE, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[10] = '{C_SHR | C_SER | C_ECL, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[11] = '{C_CLR | C_WE | C_INC, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{C_WE | C_INC, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[13] = '{C_SHL | C_ECM, 16'h0000, 16'h2468, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[14] = '{C_INC | C_DEC, 16'h0000, 16'h2469, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{C_DEC | C_SHL, 16'h0000, 16'h2468, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[16] = '{C_SHL | C_SHR | C_SER, 16'h0000, 16'h48D1, 1'b0, 1'b0, 1'b0, 1'b0};

      // Reset state.
      rst_n = 1'b0;
      drive(10'd0, 16'h0000);
      model_reset();
      #12;
      chk("rst out0", 32'(out0), 32'h0100);
      chk("rst e0",   32'(e0),   32'h0);
      chk("rst z0",   32'(z0),   32'h0);
      chk("rst o0",   32'(o0),   32'h0);
      chk("rst w0",   32'(w0),   32'h0);
      chk("rst out1", 32'(out1), 32'hFFF0);
      rst_n = 1'b1;
      step("idle");

      // Table-driven vectors.
      for (int i = 0; i < 17; i++) begin
         string t;
         t = $sformatf("vec%0d", i);
         drive(tbl[i].cmd, tbl[i].data);
         step(t);
         chk({t, " OUT"}, 32'(out0), 32'(tbl[i].out));
         chk({t, " E"},   32'(e0),   32'(tbl[i].e));
         chk({t, " zero"}, 32'(z0),  32'(tbl[i].z));
         chk({t, " ones"}, 32'(o0),  32'(tbl[i].o));
         chk({t, " wrapped"}, 32'(w0), 32'(tbl[i].w));
      end

      // Saturating instance pinned at the top, then at the bottom.
      drive(C_WE, 16'hFFFF);
      step("sat load");
      for (int k = 0; k < 3; k++) begin
         drive(C_INC, 16'h0000);
         step("sat inc");
         chk("sat inc out1", 32'(out1), 32'hFFFF);
         chk("sat inc w1",   32'(w1),   32'h1);
      end
      drive(C_WE, 16'h0000);
      step("sat load0");
      chk("sat load0 w1", 32'(w1), 32'h0);
      drive(C_DEC, 16'h0000);
      step("sat dec");
      chk("sat dec out1", 32'(out1), 32'h0000);
      chk("sat dec w1",   32'(w1),   32'h1);
      drive(10'd0, 16'h0000);
      step("sat after");

      // Reset asserted in the middle of an incr cycle: immediate, op discarded.
      drive(C_WE, 16'hFFFF);
      step("pre rst");
      drive(C_INC, 16'h0000);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midrst out0", 32'(out0), 32'h0100);
      chk("midrst w0",   32'(w0),   32'h0);
      chk("midrst e0",   32'(e0),   32'h0);
      cmp_all("midrst");
      @(posedge clk);
      #1;
      cmp_all("rst held");
      #2;
      rst_n = 1'b1;
      drive(10'd0, 16'h0000);
      step("post rst");

      // Randomized traffic with boundary-heavy load data.
      for (int n = 0; n < 400; n++) begin
         logic [9:0]  c;
         logic [15:0] d;
         int          r;
         for (int b = 0; b < 10; b++) c[b] = ($urandom_range(0, 3) == 0);
         c[3] = $urandom_range(0, 1);
         c[2] = $urandom_range(0, 1);
         r = $urandom_range(0, 3);
         d = (r == 0) ? 16'h0000 : (r == 1) ? 16'hFFFF : 16'($urandom);
         drive(c, d);
         step($sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
